// File: rtl/europa_pkg.sv
// Shared types and widths for the europa front end.
package europa_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned ADDR_W_DEFAULT = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        STOP  = 2'd2
    } ifq_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0]        word;
        logic [ADDR_W_DEFAULT-1:0] pc;
        logic                      fault;
    } ifq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Redirect, instruction-memory and decoder-side signals of the fetch queue.
// master: the fetch queue itself; slave: the surrounding memory/decoder/redirect logic.
interface instr_fetch_queue_if
    import europa_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_rsp_valid;
    logic [INSTR_W-1:0] mem_rsp_data;
    logic               mem_rsp_err;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_word;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_fault;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_err, instr_ready,
        output mem_req_valid, mem_req_addr,
        output instr_valid, instr_word, instr_pc, instr_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_err, instr_ready,
        input  mem_req_valid, mem_req_addr,
        input  instr_valid, instr_word, instr_pc, instr_fault
    );
endinterface

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry FIFO of fetched instructions with head visible
// combinationally; push and pop may coincide at any occupancy.
module ifq_fifo
    import europa_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  ifq_entry_t       i_data,
    input  logic             i_pop,
    output ifq_entry_t       o_head,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    ifq_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    // Pointer and occupancy tracking; a flush discards every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PTR_W'(1);
            if (i_pop)  r_rd <= r_rd + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Entry storage; data needs no reset since occupancy qualifies it.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    // The credit scheme upstream must never push into a full FIFO.
    always @(posedge clk) begin
        if (!rst && !i_flush && i_push && !i_pop)
            assert (r_count != CNT_W'(DEPTH));
    end

    assign o_head  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: in-order instruction fetch with credit-limited requests,
// redirect flush and stale-response discard, feeding the decoder.
// Optional: IFQ_ALIGN_CHECK_EN turns a misaligned redirect target into a fault entry.
module instr_fetch_queue
    import europa_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ifq_state_t        r_state;
    ifq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_stale;
    logic [ADDR_W-1:0] r_pc_ring [DEPTH];
    logic [PTR_W-1:0]  r_ring_wr;
    logic [PTR_W-1:0]  r_ring_rd;

    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    ifq_entry_t        w_head;
    ifq_entry_t        w_push_data;
    logic              w_push;
    logic              w_pop;
    logic              w_instr_valid;
    logic              w_req_valid;
    logic              w_accept;
    logic [CNT_W:0]    w_inflight;
    logic              w_rsp_stale;
    logic              w_rsp_push;
    logic              w_rsp_fault;
    logic [CNT_W-1:0]  w_out_nxt;
    logic [CNT_W-1:0]  w_stale_dec;
    logic [ADDR_W-1:0] w_redir_pc;
    logic              w_misalign;
    logic              w_align_pend;
    logic [ADDR_W-1:0] w_align_pc;
    logic              w_align_push;

`ifdef IFQ_ALIGN_CHECK_EN
    logic              r_align_pend;
    logic [ADDR_W-1:0] r_align_pc;

    assign w_redir_pc   = bus.redirect_pc;
    assign w_misalign   = (bus.redirect_pc[1:0] != 2'b00);
    assign w_align_pend = r_align_pend;
    assign w_align_pc   = r_align_pc;

    // Pending misaligned-target fault, emitted once stale responses have drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_align_pend <= 1'b0;
            r_align_pc   <= '0;
        end else if (bus.redirect_valid) begin
            r_align_pend <= w_misalign;
            r_align_pc   <= bus.redirect_pc;
        end else if (w_align_push) begin
            r_align_pend <= 1'b0;
        end
    end
`else
    assign w_redir_pc   = bus.redirect_pc & ~ADDR_W'(3);
    assign w_misalign   = 1'b0;
    assign w_align_pend = 1'b0;
    assign w_align_pc   = '0;
`endif

    // Every response retires one outstanding request; only non-stale ones are kept.
    assign w_rsp_stale  = (r_stale != '0);
    assign w_rsp_push   = bus.mem_rsp_valid && !w_rsp_stale && !bus.redirect_valid;
    assign w_rsp_fault  = w_rsp_push && bus.mem_rsp_err;
    assign w_accept     = w_req_valid && bus.mem_req_ready;
    assign w_out_nxt    = r_outstanding + CNT_W'(w_accept) - CNT_W'(bus.mem_rsp_valid);
    assign w_stale_dec  = r_stale - CNT_W'(bus.mem_rsp_valid && w_rsp_stale);
    assign w_inflight   = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign w_align_push = w_align_pend && (r_state == DRAIN) && !w_rsp_stale
                          && !bus.redirect_valid;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // FSM next state; redirect overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_valid) begin
            w_state_nxt = ((w_out_nxt != '0) || w_misalign) ? DRAIN : RUN;
        end else begin
            case (r_state)
                RUN:     if (w_rsp_fault) w_state_nxt = STOP;
                DRAIN: begin
                    if (w_align_pend) begin
                        if (!w_rsp_stale) w_state_nxt = STOP;
                    end else if (w_stale_dec == '0) begin
                        w_state_nxt = RUN;
                    end
                end
                STOP:    w_state_nxt = STOP;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // FSM outputs: request issue under credit, FIFO push selection.
    always_comb begin
        w_req_valid = 1'b0;
        w_push      = 1'b0;
        w_push_data = '0;
        if ((r_state == RUN) && !bus.redirect_valid && !rst)
            w_req_valid = (w_inflight < (CNT_W + 1)'(DEPTH));
        if (w_align_push) begin
            w_push            = 1'b1;
            w_push_data.pc    = ADDR_W_DEFAULT'(w_align_pc);
            w_push_data.fault = 1'b1;
        end else if (w_rsp_push) begin
            w_push            = 1'b1;
            w_push_data.word  = bus.mem_rsp_err ? '0 : bus.mem_rsp_data;
            w_push_data.pc    = ADDR_W_DEFAULT'(r_pc_ring[r_ring_rd]);
            w_push_data.fault = bus.mem_rsp_err;
        end
    end

    // Fetch PC, outstanding/stale counters and request-PC ring pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_stale       <= '0;
            r_ring_wr     <= '0;
            r_ring_rd     <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            if (w_accept)          r_ring_wr <= r_ring_wr + PTR_W'(1);
            if (bus.mem_rsp_valid) r_ring_rd <= r_ring_rd + PTR_W'(1);
            if (bus.redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_stale    <= w_out_nxt;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                r_stale <= w_rsp_fault ? w_out_nxt : w_stale_dec;
            end
        end
    end

    // PC of each issued request, read back in order when its response returns.
    always_ff @(posedge clk) begin
        if (w_accept) r_pc_ring[r_ring_wr] <= r_fetch_pc;
    end

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_instr_valid     = !w_fifo_empty && !bus.redirect_valid;
    assign w_pop             = w_instr_valid && bus.instr_ready;
    assign bus.instr_valid   = w_instr_valid;
    assign bus.instr_word    = w_head.word;
    assign bus.instr_pc      = ADDR_W'(w_head.pc);
    assign bus.instr_fault   = w_head.fault;
    assign bus.mem_req_valid = w_req_valid;
    assign bus.mem_req_addr  = r_fetch_pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a queue-based reference model.
// Honors IFQ_ALIGN_CHECK_EN the same way the design does.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_fetch_queue_if #(.ADDR_W(64)) bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] pc;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] word;
        logic [63:0] pc;
        bit          fault;
    } ent_t;

    req_t        outq[$];
    ent_t        fq[$];
    logic [63:0] m_pc;
    bit          m_stopped;
    bit          m_pend;
    logic [63:0] m_pend_pc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle per iteration: drive at negedge, check after settling, advance model.
    task automatic run_phase(input int cycles, input int pr, input int prsp, input int pir,
                             input int predir, input int perr, output int n_acc);
        bit          redir, any_stale, exp_req, exp_iv, acc, pop;
        logic [63:0] rpc;
        req_t        rec;
        ent_t        e;
        n_acc = 0;
        for (int c = 0; c < cycles; c++) begin
            redir = ($urandom_range(99) < predir);
            case ($urandom_range(3))
                0:       rpc = 64'hFFFF_FFFF_FFFF_FFF8;
                1:       rpc = 64'h100 | 64'($urandom_range(3));
                default: rpc = {32'($urandom), 32'($urandom)};
            endcase
            bus.redirect_valid = redir;
            bus.redirect_pc    = rpc;
            bus.mem_req_ready  = ($urandom_range(99) < pr);
            bus.mem_rsp_valid  = (outq.size() > 0) && ($urandom_range(99) < prsp);
            bus.mem_rsp_data   = 32'($urandom);
            bus.mem_rsp_err    = bus.mem_rsp_valid && ($urandom_range(999) < perr);
            bus.instr_ready    = ($urandom_range(99) < pir);
            #1;

            any_stale = 1'b0;
            foreach (outq[i]) if (outq[i].stale) any_stale = 1'b1;
            exp_req = !redir && !m_stopped && !m_pend && !any_stale
                      && (fq.size() + outq.size() < DEPTH);
            exp_iv  = !redir && (fq.size() > 0);

            check_eq("req_valid", 64'(bus.mem_req_valid), 64'(exp_req));
            if (exp_req) check_eq("req_addr", bus.mem_req_addr, m_pc);
            check_eq("instr_valid", 64'(bus.instr_valid), 64'(exp_iv));
            if (exp_iv) begin
                check_eq("instr_word", 64'(bus.instr_word), 64'(fq[0].word));
                check_eq("instr_pc", bus.instr_pc, fq[0].pc);
                check_eq("instr_fault", 64'(bus.instr_fault), 64'(fq[0].fault));
            end

            acc = exp_req && bus.mem_req_ready;
            pop = exp_iv && bus.instr_ready;
            if (bus.mem_req_valid && bus.mem_req_ready) n_acc++;
            if (bus.mem_rsp_valid) rec = outq.pop_front();

            if (redir) begin
                fq.delete();
                foreach (outq[i]) outq[i].stale = 1'b1;
                m_stopped = 1'b0;
`ifdef IFQ_ALIGN_CHECK_EN
                m_pc      = rpc;
                m_pend    = (rpc[1:0] != 2'b00);
                m_pend_pc = rpc;
`else
                m_pc   = rpc & ~64'h3;
                m_pend = 1'b0;
`endif
            end else begin
                if (m_pend && !any_stale) begin
                    e = '{word: 32'h0, pc: m_pend_pc, fault: 1'b1};
                    fq.push_back(e);
                    m_pend    = 1'b0;
                    m_stopped = 1'b1;
                end
                if (pop) void'(fq.pop_front());
                if (acc) begin
                    outq.push_back('{pc: m_pc, stale: 1'b0});
                    m_pc = m_pc + 64'h4;
                end
                if (bus.mem_rsp_valid && !rec.stale) begin
                    e.word  = bus.mem_rsp_err ? 32'h0 : bus.mem_rsp_data;
                    e.pc    = rec.pc;
                    e.fault = bus.mem_rsp_err;
                    fq.push_back(e);
                    if (bus.mem_rsp_err) begin
                        m_stopped = 1'b1;
                        foreach (outq[i]) outq[i].stale = 1'b1;
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int acc_cnt;
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
        bus.mem_rsp_err    = 1'b0;
        bus.instr_ready    = 1'b0;
        m_pc      = 64'h0;
        m_stopped = 1'b0;
        m_pend    = 1'b0;
        m_pend_pc = '0;

        repeat (2) @(negedge clk);
        bus.mem_req_ready = 1'b1;
        #1;
        check_eq("rst_req_valid", 64'(bus.mem_req_valid), 64'h0);
        check_eq("rst_instr_valid", 64'(bus.instr_valid), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Decoder stalled: credit limit allows exactly DEPTH requests.
        run_phase(20, 100, 100, 0, 0, 0, acc_cnt);
        check_eq("credit_reqs", 64'(acc_cnt), 64'(DEPTH));
        // Streaming with everyone ready: in-order pcs.
        run_phase(30, 100, 100, 100, 0, 0, acc_cnt);
        // Mixed traffic with redirects and faults.
        run_phase(400, 50, 50, 60, 5, 20, acc_cnt);
        // Busy pipe: frequent redirects colliding with responses and handshakes.
        run_phase(400, 90, 90, 90, 15, 50, acc_cnt);
        // Slow memory and slow decoder.
        run_phase(300, 70, 30, 30, 3, 10, acc_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
